// File: rtl/tlul_csr_pkg.sv
// Shared constants and helpers for the TL-UL CSR access tracker.
// Covers the legal opcodes, the error-pulse bit positions and byte-mask expansion.
package tlul_csr_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam int unsigned ErrOverflow    = 0;
    localparam int unsigned ErrUnexpectedD = 1;
    localparam int unsigned ErrSrcMismatch = 2;
    localparam int unsigned ErrDError      = 3;
    localparam int unsigned ErrIllegalOp   = 4;
    localparam int unsigned ErrW           = 5;

    // Widest data bus the mask helper supports; callers pad and truncate.
    localparam int unsigned MaxDW    = 256;
    localparam int unsigned MaxMaskW = MaxDW / 8;

    function automatic logic [MaxDW-1:0] expand_mask(input logic [MaxMaskW-1:0] mask);
        logic [MaxDW-1:0] bits;
        bits = '0;
        for (int i = 0; i < MaxMaskW; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/csr_req_fifo.sv
// Generic synchronous FIFO with occupancy count.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module csr_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        if (do_push) wptr_d = wptr_q + PtrW'(1);
        if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tlul_csr_access_tracker.sv
// Passive TL-UL observer: pairs A requests with in-order D responses, emits completed-access
// strobes and flags protocol errors and response timeouts.
module tlul_csr_access_tracker
    import tlul_csr_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned SRC_W   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             a_valid_i,
    input  logic             a_ready_i,
    input  logic [2:0]       a_opcode_i,
    input  logic [SRC_W-1:0] a_source_i,
    input  logic [AW-1:0]    a_address_i,
    input  logic [DW-1:0]    a_data_i,
    input  logic [DW/8-1:0]  a_mask_i,
    input  logic             d_valid_i,
    input  logic             d_ready_i,
    input  logic [SRC_W-1:0] d_source_i,
    input  logic [DW-1:0]    d_data_i,
    input  logic             d_error_i,
    output logic             wr_o,
    output logic             rd_o,
    output logic [AW-1:0]    addr_o,
    output logic [DW-1:0]    wdata_o,
    output logic [DW/8-1:0]  wmask_o,
    output logic [DW-1:0]    rdata_o,
    output logic [CntW-1:0]  outstanding_o,
    output logic [ErrW-1:0]  err_pulse_o,
    output logic             err_timeout_o
);

    typedef struct packed {
        logic             is_wr;
        logic [SRC_W-1:0] src;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
        logic [DW/8-1:0]  mask;
    } entry_t;

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    entry_t          push_entry, head;
    logic            a_hs, d_hs, legal_op, push, fifo_full, fifo_empty, pop, src_ok, complete;
    logic [CntW-1:0] count;

    logic            wr_q, wr_d, rd_q, rd_d, timeout_q, timeout_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DW/8-1:0] wmask_q, wmask_d;
    logic [ErrW-1:0] err_q, err_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;

    assign a_hs     = a_valid_i & a_ready_i;
    assign d_hs     = d_valid_i & d_ready_i;
    assign legal_op = (a_opcode_i == PutFullData) || (a_opcode_i == PutPartialData) ||
                      (a_opcode_i == Get);
    assign push     = a_hs & legal_op;
    // No A-to-D bypass: an empty FIFO at cycle start means the response is unexpected.
    assign pop      = d_hs & ~fifo_empty;
    assign src_ok   = (d_source_i == head.src);
    assign complete = pop & src_ok & ~d_error_i;

    always_comb begin
        push_entry.is_wr = (a_opcode_i != Get);
        push_entry.src   = a_source_i;
        push_entry.addr  = a_address_i;
        push_entry.data  = a_data_i & DW'(expand_mask(MaxMaskW'(a_mask_i)));
        push_entry.mask  = a_mask_i;
    end

    csr_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        err_d                 = '0;
        err_d[ErrOverflow]    = push & fifo_full & ~pop;
        err_d[ErrUnexpectedD] = d_hs & fifo_empty;
        err_d[ErrSrcMismatch] = pop & ~src_ok;
        err_d[ErrDError]      = pop & src_ok & d_error_i;
        err_d[ErrIllegalOp]   = a_hs & ~legal_op;

        wr_d    = complete & head.is_wr;
        rd_d    = complete & ~head.is_wr;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        if (complete) begin
            addr_d  = head.addr;
            wdata_d = head.data;
            wmask_d = head.mask;
            rdata_d = head.is_wr ? '0 : d_data_i;
        end
    end

    always_comb begin
        tcnt_d = tcnt_q;
        if (TIMEOUT == 0 || count == '0 || d_hs) begin
            tcnt_d = '0;
        end else if (tcnt_q != TW'(TIMEOUT)) begin
            tcnt_d = tcnt_q + TW'(1);
        end
        timeout_d = timeout_q | ((TIMEOUT != 0) && (tcnt_d == TW'(TIMEOUT)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign wr_o          = wr_q;
    assign rd_o          = rd_q;
    assign addr_o        = addr_q;
    assign wdata_o       = wdata_q;
    assign wmask_o       = wmask_q;
    assign rdata_o       = rdata_q;
    assign err_pulse_o   = err_q;
    assign err_timeout_o = timeout_q;
    assign outstanding_o = count;

endmodule
